// File: rtl/pipe_mux_tree.sv
// Pipelined NUM_IN:1 binary mux tree; select echoed to out_sel when PMUX_SEL_ECHO_EN is defined.
// Latency: PIPE_STAGES register loads, so an item accepted on edge N is visible after edge N+PIPE_STAGES-1.
// Backpressure: combinational ready chain; bubbles collapse and a full pipe accepts and retires on one edge.
module pipe_mux_tree #(
  parameter int NUM_IN      = 16,
  parameter int DATA_W      = 8,
  parameter int PIPE_STAGES = 2,
  localparam int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
`ifdef PMUX_SEL_ECHO_EN
  output logic [SEL_W-1:0]         out_sel,
`endif
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int L = SEL_W;
  localparam int P = PIPE_STAGES;

  logic [P-1:0] v;
  logic [P-1:0] rdy;

  genvar s, j, k;
  for (s = 0; s < P; s++) begin : g_stage
    localparam int LO    = s * L / P;
    localparam int HI    = (s + 1) * L / P;
    localparam int IN_W  = (NUM_IN >> LO) * DATA_W;
    localparam int OUT_W = (NUM_IN >> HI) * DATA_W;
`ifdef PMUX_SEL_ECHO_EN
    localparam int SI_W   = L;
    localparam int SI_OFF = 0;
    localparam int SO_W   = L;
`else
    // Only the select bits of levels not yet evaluated are carried forward.
    localparam int SI_W   = L - LO;
    localparam int SI_OFF = LO;
    localparam int SO_W   = L - HI;
`endif

    logic [IN_W-1:0]  d_in;
    logic [SI_W-1:0]  s_in;
    logic             up_vld;
    logic             v_q;
    logic [OUT_W-1:0] d_q;
    logic [OUT_W-1:0] d_nxt;

    if (s == 0) begin : g_src
      assign d_in   = in_data;
      assign s_in   = in_sel;
      assign up_vld = in_valid;
    end else begin : g_src
      assign d_in   = g_stage[s-1].d_q;
      assign s_in   = g_stage[s-1].g_sel.sel_q;
      assign up_vld = v[s-1];
    end

    for (j = LO; j < HI; j++) begin : g_lvl
      logic [(NUM_IN>>j)*DATA_W-1:0]     x;
      logic [(NUM_IN>>(j+1))*DATA_W-1:0] y;
      if (j == LO) begin : g_x
        assign x = d_in;
      end else begin : g_x
        assign x = g_lvl[j-1].y;
      end
      for (k = 0; k < (NUM_IN >> (j + 1)); k++) begin : g_mux
        assign y[k*DATA_W +: DATA_W] = s_in[j-SI_OFF] ? x[(2*k+1)*DATA_W +: DATA_W]
                                                      : x[2*k*DATA_W +: DATA_W];
      end
    end
    assign d_nxt = g_lvl[HI-1].y;

    // Equivalent to rdy[s] = !v[s] || rdy[s+1], unrolled to avoid a self-referencing vector.
    assign rdy[s] = out_ready || !(&v[P-1:s]);
    assign v[s]   = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (rdy[s]) begin
        v_q <= up_vld;
        if (up_vld) d_q <= d_nxt;
      end
    end

    if (SO_W > 0) begin : g_sel
      logic [SO_W-1:0] sel_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_q <= '0;
        else if (rdy[s] && up_vld) sel_q <= s_in[SI_W-1 -: SO_W];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[P-1];
  assign out_data  = g_stage[P-1].d_q;
`ifdef PMUX_SEL_ECHO_EN
  assign out_sel   = g_stage[P-1].g_sel.sel_q;
`endif

endmodule
